// File: rtl/apb_master_bridge.sv
// Valid/ready command channel to single APB4 transfers, one outstanding at a time.
// Optional ACCESS-phase watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK_i,
    input  logic                    PRESETn_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0]   PADDR_o,
    output logic                    PWRITE_o,
    output logic [DATA_WIDTH-1:0]   PWDATA_o,
    output logic [DATA_WIDTH/8-1:0] PSTRB_o,
    output logic                    PSEL_o,
    output logic                    PENABLE_o,
    input  logic [DATA_WIDTH-1:0]   PRDATA_i,
    input  logic                    PREADY_i,
    input  logic                    PSLVERR_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
`endif

    // State and output registers; every output is a flop.
    always_ff @(posedge PCLK_i) begin
        if (!PRESETn_i) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    // Next-state logic; outputs are computed for the state being entered.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    state_d     = S_SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    paddr_d     = cmd_addr_i;
                    pwrite_d    = cmd_write_i;
                    // Reads never present write data or strobes on the bus.
                    pwdata_d    = cmd_write_i ? cmd_wdata_i : '0;
                    pstrb_d     = cmd_write_i ? cmd_strb_i : '0;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end

            S_SETUP: begin
                state_d   = S_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end

            S_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                if (PREADY_i) begin
                    state_d     = S_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA_i;
                    rsp_err_d   = PSLVERR_i;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = S_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
`endif
                end
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready_o = cmd_ready_q;
    assign PSEL_o      = psel_q;
    assign PENABLE_o   = penable_q;
    assign PADDR_o     = paddr_q;
    assign PWRITE_o    = pwrite_q;
    assign PWDATA_o    = pwdata_q;
    assign PSTRB_o     = pstrb_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_timeout_o = rsp_timeout_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

endmodule
